// File: rtl/mult_dual_pkg.sv
// Shared constants and helpers for the packed dual multiplier.
// The DSP limits are the 27-bit pre-adder and the 18-bit B port. The packing
// offset and the product width are derived from DATA_W. The legality checks
// are evaluated at elaboration time by the top module.
package mult_dual_pkg;

  localparam int DSP_PREADD_W = 27;
  localparam int DSP_B_W      = 18;
  localparam int DATA_W_MIN   = 4;
  localparam int DATA_W_MAX   = 8;

  // The offset leaves two guard bits above b*c, so the low product cannot
  // spill into the a*c field.
  function automatic int shift_of(input int data_w);
    return 2 * data_w + 2;
  endfunction

  function automatic int prod_w_of(input int data_w);
    return 2 * data_w;
  endfunction

  // The packed operand has to fit the pre-adder, and the sign-extended c has
  // to fit the B port.
  function automatic bit data_w_ok(input int data_w);
    return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
           (shift_of(data_w) + data_w + 1 <= DSP_PREADD_W) &&
           (data_w + 1 <= DSP_B_W);
  endfunction

  // The accumulator sign-extends the product, so it needs at least one bit
  // more than the product.
  function automatic bit acc_w_ok(input int data_w, input int acc_w);
    return acc_w > prod_w_of(data_w);
  endfunction

endpackage

// File: rtl/mult_dual_acc.sv
// Two-channel burst accumulator placed after the unpack stage. It sums the
// products of every beat in a burst and presents the completed sums once, on
// the beat that carries last. The sums wrap modulo 2^ACC_W.
module mult_dual_acc #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic              i_last,
  input  logic [PROD_W-1:0] i_prod_ac,
  input  logic [PROD_W-1:0] i_prod_bc,
  output logic              o_valid,
  output logic              o_last,
  output logic [ACC_W-1:0]  o_acc_ac,
  output logic [ACC_W-1:0]  o_acc_bc
);

  logic             r_first;
  logic             r_valid;
  logic             r_last;
  logic [ACC_W-1:0] r_acc_ac;
  logic [ACC_W-1:0] r_acc_bc;
  logic             w_sx_ac;
  logic             w_sx_bc;
  logic [ACC_W-1:0] w_ext_ac;
  logic [ACC_W-1:0] w_ext_bc;
  logic [ACC_W-1:0] w_base_ac;
  logic [ACC_W-1:0] w_base_bc;

  assign w_sx_ac   = (SIGNED != 0) & i_prod_ac[PROD_W-1];
  assign w_sx_bc   = (SIGNED != 0) & i_prod_bc[PROD_W-1];
  assign w_ext_ac  = {{(ACC_W-PROD_W){w_sx_ac}}, i_prod_ac};
  assign w_ext_bc  = {{(ACC_W-PROD_W){w_sx_bc}}, i_prod_bc};
  assign w_base_ac = r_first ? '0 : r_acc_ac;
  assign w_base_bc = r_first ? '0 : r_acc_bc;

  // Accumulate each beat. The first beat of a burst restarts the sums, and
  // only a last beat raises the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_first  <= 1'b1;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_acc_ac <= '0;
      r_acc_bc <= '0;
    end else if (i_en) begin
      r_valid <= i_valid & i_last;
      r_last  <= i_valid & i_last;
      if (i_valid) begin
        r_acc_ac <= w_base_ac + w_ext_ac;
        r_acc_bc <= w_base_bc + w_ext_bc;
        r_first  <= i_last;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_last   = r_last;
  assign o_acc_ac = r_acc_ac;
  assign o_acc_bc = r_acc_bc;

endmodule

// File: rtl/mult_dual_packed_pipe.sv
// Computes the two products a*c and b*c, which share the multiplier c, on a
// single DSP multiplier by packing a and b into one operand:
// (a << SHIFT) + b. The pipeline has three stages (pre-add, multiply, unpack).
// It uses a valid/ready handshake and freezes as a whole under backpressure.
// Optional macro MULT_DUAL_ACC_EN adds a fourth stage, a per-burst
// accumulator, and the outputs then widen to ACC_W.
module mult_dual_packed_pipe
  import mult_dual_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SIGNED = 1,
  parameter int ACC_W  = 24
`ifdef MULT_DUAL_ACC_EN
  , localparam int OUT_W = ACC_W
`else
  , localparam int OUT_W = 2 * DATA_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic              i_last,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [OUT_W-1:0]  prod_ac,
  output logic [OUT_W-1:0]  prod_bc,
  output logic              o_last,
  output logic              o_valid,
  input  logic              o_ready
);

  localparam int SHIFT  = shift_of(DATA_W);
  localparam int PROD_W = prod_w_of(DATA_W);
  localparam int PRE_W  = SHIFT + DATA_W + 1;
  localparam int M_W    = SHIFT + PROD_W;

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("mult_dual_packed_pipe: DATA_W=%0d outside %0d..%0d", DATA_W, DATA_W_MIN, DATA_W_MAX);
  end

`ifdef MULT_DUAL_ACC_EN
  if (!acc_w_ok(DATA_W, ACC_W)) begin : g_bad_acc_w
    $error("mult_dual_packed_pipe: ACC_W=%0d must exceed %0d", ACC_W, PROD_W);
  end
`else
  localparam int ACC_W_UNUSED = ACC_W;
`endif

  logic              w_en;
  logic              w_sa;
  logic              w_sb;
  logic [PRE_W-1:0]  w_a_ext;
  logic [PRE_W-1:0]  w_b_ext;
  logic [PRE_W-1:0]  w_pre;
  logic              w_sp;
  logic              w_sc;
  logic [M_W-1:0]    w_pre_x;
  logic [M_W-1:0]    w_c_x;
  logic [M_W-1:0]    w_m;
  logic              w_borrow;
  logic              w_unused_m;

  logic              r_v1, r_v2, r_v3;
  logic              r_l1, r_l2, r_l3;
  logic [PRE_W-1:0]  r_pre;
  logic [DATA_W-1:0] r_c;
  logic [M_W-1:0]    r_m;
  logic [PROD_W-1:0] r_prod_ac;
  logic [PROD_W-1:0] r_prod_bc;

  assign w_en    = ~o_valid | o_ready;
  assign i_ready = w_en;

  // The pre-adder uses wrap-around arithmetic: a negative b borrows from the
  // a field, and the unpack stage repays that borrow.
  assign w_sa    = (SIGNED != 0) & a[DATA_W-1];
  assign w_sb    = (SIGNED != 0) & b[DATA_W-1];
  assign w_a_ext = {{(PRE_W-DATA_W){w_sa}}, a};
  assign w_b_ext = {{(PRE_W-DATA_W){w_sb}}, b};
  assign w_pre   = (w_a_ext << SHIFT) + w_b_ext;

  // The operands are extended to the kept width, so the modular product
  // matches the signed product in every retained bit.
  assign w_sp    = (SIGNED != 0) & r_pre[PRE_W-1];
  assign w_sc    = (SIGNED != 0) & r_c[DATA_W-1];
  assign w_pre_x = {{(M_W-PRE_W){w_sp}}, r_pre};
  assign w_c_x   = {{(M_W-DATA_W){w_sc}}, r_c};
  assign w_m     = w_pre_x * w_c_x;

  assign w_borrow   = (SIGNED != 0) & r_m[SHIFT-1];
  assign w_unused_m = ^r_m[SHIFT-1:PROD_W];

  // Stage 1: register the packed operand and the shared multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_l1  <= 1'b0;
      r_pre <= '0;
      r_c   <= '0;
    end else if (w_en) begin
      r_v1 <= i_valid;
      r_l1 <= i_valid & i_last;
      if (i_valid) begin
        r_pre <= w_pre;
        r_c   <= c;
      end
    end
  end

  // Stage 2: the single wide multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_l2 <= 1'b0;
      r_m  <= '0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      if (r_v1) begin
        r_m <= w_m;
      end
    end
  end

  // Stage 3: split the packed product and apply the borrow correction to a*c.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3      <= 1'b0;
      r_l3      <= 1'b0;
      r_prod_ac <= '0;
      r_prod_bc <= '0;
    end else if (w_en) begin
      r_v3 <= r_v2;
      r_l3 <= r_l2;
      if (r_v2) begin
        r_prod_bc <= r_m[PROD_W-1:0];
        r_prod_ac <= r_m[M_W-1:SHIFT] + {{(PROD_W-1){1'b0}}, w_borrow};
      end
    end
  end

`ifdef MULT_DUAL_ACC_EN
  mult_dual_acc #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_en),
    .i_valid   (r_v3),
    .i_last    (r_l3),
    .i_prod_ac (r_prod_ac),
    .i_prod_bc (r_prod_bc),
    .o_valid   (o_valid),
    .o_last    (o_last),
    .o_acc_ac  (prod_ac),
    .o_acc_bc  (prod_bc)
  );
`else
  assign o_valid = r_v3;
  assign o_last  = r_l3;
  assign prod_ac = r_prod_ac;
  assign prod_bc = r_prod_bc;
`endif

endmodule

// File: tb/tb_mult_dual_packed_pipe.sv
// Scoreboard bench for mult_dual_packed_pipe. It drives a signed instance and
// an unsigned instance with the same stimulus and checks both against
// arithmetic reference products.
module tb_mult_dual_packed_pipe;

`ifdef MULT_DUAL_ACC_EN
  localparam int OUT_W = 24;
  localparam int LAT   = 4;
`else
  localparam int OUT_W = 16;
  localparam int LAT   = 3;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] ac;
    logic [OUT_W-1:0] bc;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       a = '0, b = '0, c = '0;
  logic             i_last = 1'b0, i_valid = 1'b0, o_ready = 1'b1;
  logic             i_ready_s, i_ready_u;
  logic [OUT_W-1:0] prod_ac_s, prod_bc_s, prod_ac_u, prod_bc_u;
  logic             o_last_s, o_last_u, o_valid_s, o_valid_u;

  int checks = 0;
  int failures = 0;
  int rdy_pct = 100;
  int stall_cnt = 0;
  exp_t q_s[$];
  exp_t q_u[$];
  longint sum_s_ac = 0, sum_s_bc = 0, sum_u_ac = 0, sum_u_bc = 0;

  mult_dual_packed_pipe #(.DATA_W(8), .SIGNED(1), .ACC_W(24)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .i_last(i_last), .i_valid(i_valid),
    .i_ready(i_ready_s), .prod_ac(prod_ac_s), .prod_bc(prod_bc_s), .o_last(o_last_s),
    .o_valid(o_valid_s), .o_ready(o_ready));

  mult_dual_packed_pipe #(.DATA_W(8), .SIGNED(0), .ACC_W(24)) dut_u (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .i_last(i_last), .i_valid(i_valid),
    .i_ready(i_ready_u), .prod_ac(prod_ac_u), .prod_bc(prod_bc_u), .o_last(o_last_u),
    .o_valid(o_valid_u), .o_ready(o_ready));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int prod_of(input logic [7:0] x, input logic [7:0] y, input bit sgn);
    int xi, yi;
    if (sgn) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    return xi * yi;
  endfunction

  task automatic model_accept(input logic [7:0] ta, tb, tc, input logic tl);
    exp_t e;
    int pac_s, pbc_s, pac_u, pbc_u;
    pac_s = prod_of(ta, tc, 1'b1);
    pbc_s = prod_of(tb, tc, 1'b1);
    pac_u = prod_of(ta, tc, 1'b0);
    pbc_u = prod_of(tb, tc, 1'b0);
`ifdef MULT_DUAL_ACC_EN
    sum_s_ac += longint'(pac_s);
    sum_s_bc += longint'(pbc_s);
    sum_u_ac += longint'(pac_u);
    sum_u_bc += longint'(pbc_u);
    if (tl) begin
      e.ac = OUT_W'(sum_s_ac); e.bc = OUT_W'(sum_s_bc); e.last = 1'b1;
      q_s.push_back(e);
      e.ac = OUT_W'(sum_u_ac); e.bc = OUT_W'(sum_u_bc); e.last = 1'b1;
      q_u.push_back(e);
      sum_s_ac = 0; sum_s_bc = 0; sum_u_ac = 0; sum_u_bc = 0;
    end
`else
    e.ac = OUT_W'(pac_s); e.bc = OUT_W'(pbc_s); e.last = tl;
    q_s.push_back(e);
    e.ac = OUT_W'(pac_u); e.bc = OUT_W'(pbc_u); e.last = tl;
    q_u.push_back(e);
`endif
  endtask

  // Ready generator: random with a given percentage, or forced low for stalls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        o_ready = 1'b0;
        stall_cnt--;
      end else begin
        o_ready = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks that the
  // outputs hold while they are stalled.
  initial begin
    exp_t e;
    bit hold_s = 0, hold_u = 0;
    logic [OUT_W-1:0] h_ac_s, h_bc_s, h_ac_u, h_bc_u;
    logic h_l_s, h_l_u;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_s = 0;
        hold_u = 0;
      end else begin
        if (hold_s) begin
          chk("hold_valid_s", 64'(o_valid_s), 64'd1);
          chk("hold_ac_s", 64'(prod_ac_s), 64'(h_ac_s));
          chk("hold_bc_s", 64'(prod_bc_s), 64'(h_bc_s));
          chk("hold_last_s", 64'(o_last_s), 64'(h_l_s));
        end
        if (hold_u) begin
          chk("hold_ac_u", 64'(prod_ac_u), 64'(h_ac_u));
          chk("hold_bc_u", 64'(prod_bc_u), 64'(h_bc_u));
          chk("hold_last_u", 64'(o_last_u), 64'(h_l_u));
        end
        if (o_valid_s && !o_ready) chk("iready_stalled", 64'(i_ready_s), 64'd0);
        if (o_valid_s && o_ready) begin
          if (q_s.size() == 0) begin
            chk("unexpected_out_s", 64'(o_valid_s), 64'd0);
          end else begin
            e = q_s.pop_front();
            chk("prod_ac_s", 64'(prod_ac_s), 64'(e.ac));
            chk("prod_bc_s", 64'(prod_bc_s), 64'(e.bc));
            chk("o_last_s", 64'(o_last_s), 64'(e.last));
          end
        end
        if (o_valid_u && o_ready) begin
          if (q_u.size() == 0) begin
            chk("unexpected_out_u", 64'(o_valid_u), 64'd0);
          end else begin
            e = q_u.pop_front();
            chk("prod_ac_u", 64'(prod_ac_u), 64'(e.ac));
            chk("prod_bc_u", 64'(prod_bc_u), 64'(e.bc));
            chk("o_last_u", 64'(o_last_u), 64'(e.last));
          end
        end
        hold_s = o_valid_s && !o_ready;
        hold_u = o_valid_u && !o_ready;
        h_ac_s = prod_ac_s; h_bc_s = prod_bc_s; h_l_s = o_last_s;
        h_ac_u = prod_ac_u; h_bc_u = prod_bc_u; h_l_u = o_last_u;
      end
    end
  end

  task automatic send(input logic [7:0] ta, tb, tc, input logic tl);
    bit done = 0;
    int guard = 0;
    a = ta; b = tb; c = tc; i_last = tl; i_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (i_ready_s) begin
        model_accept(ta, tb, tc, tl);
        done = 1;
      end else if (++guard > 200) begin
        chk("accept_timeout", 64'(i_ready_s), 64'd1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    q_s.delete();
    q_u.delete();
    sum_s_ac = 0; sum_s_bc = 0; sum_u_ac = 0; sum_u_bc = 0;
    rst = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    rdy_pct = 100;
    while ((q_s.size() != 0 || q_u.size() != 0) && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    idle(2);
    chk("drain_q_s", 64'(q_s.size()), 64'd0);
    chk("drain_q_u", 64'(q_u.size()), 64'd0);
  endtask

  initial begin
    do_reset(3);
    @(negedge clk);
    chk("rst_o_valid_s", 64'(o_valid_s), 64'd0);
    chk("rst_o_valid_u", 64'(o_valid_u), 64'd0);
    chk("rst_o_last", 64'(o_last_s), 64'd0);
    chk("rst_prod_ac", 64'(prod_ac_s), 64'd0);
    chk("rst_prod_bc", 64'(prod_bc_s), 64'd0);
    chk("rst_i_ready", 64'(i_ready_s), 64'd1);
    @(posedge clk);
    #1;

    // Single beat: the output appears exactly LAT cycles after acceptance, for one cycle.
    rdy_pct = 100;
    idle(2);
    send(8'd5, 8'hFD, 8'd7, 1'b1);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk($sformatf("latency_valid_c%0d", k), 64'(o_valid_s), 64'(k == LAT));
    end
    @(posedge clk);
    #1;

    send(8'h80, 8'h80, 8'h80, 1'b1);
    send(8'h7F, 8'h80, 8'hFF, 1'b1);
    send(8'hFF, 8'hFF, 8'hFF, 1'b1);
    send(8'h00, 8'h01, 8'hFF, 1'b1);
    send(8'h80, 8'h80, 8'h7F, 1'b1);
    drain();

    // Back-to-back burst with the output stalled for four cycles.
    fork
      begin
        repeat (4) @(posedge clk);
        stall_cnt = 4;
      end
    join_none
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), 1'(i % 2));
    end
    drain();

    // Reset with two beats in flight: nothing may emerge afterwards.
    send(8'd9, 8'd9, 8'd9, 1'b1);
    send(8'd8, 8'd8, 8'd8, 1'b1);
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(o_valid_s | o_valid_u), 64'd0);
    end
    @(posedge clk);
    #1;
    send(8'd2, 8'd3, 8'd4, 1'b1);
    drain();

`ifdef MULT_DUAL_ACC_EN
    send(8'd1, 8'hFF, 8'd4, 1'b0);
    send(8'd2, 8'hFF, 8'd4, 1'b0);
    send(8'd3, 8'hFF, 8'd4, 1'b1);
    send(8'd1, 8'd0, 8'd1, 1'b1);
    drain();
`endif

    // Randomised traffic with random backpressure and idle gaps.
    rdy_pct = 70;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(3) == 0) || (i == 299));
      if ($urandom_range(4) == 0) idle($urandom_range(2));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_dual_packed_pipe.md
Name: mult_dual_packed_pipe

Overview:
- Parametrised successor of the fixed 8-bit dual multiplier.
- Computes two products that share a multiplicand, a*c and b*c, on one DSP multiplier using operand packing.
- Adds a width parameter, a signed/unsigned mode and a full valid/ready handshake with backpressure.
- Sits in the conv/PE datapath between the weight/activation fetch and the accumulator tree.

Parameters:
- DATA_W, 8, width of a, b and c; legal range 4..8 so the packed operand fits the 27-bit DSP pre-adder.
- SIGNED, 1, 1 means two's-complement operands with borrow correction; 0 means unsigned operands.
- ACC_W, 24, accumulator/output width; used only when MULT_DUAL_ACC_EN is defined.
- Derived localparam SHIFT = 2*DATA_W+2, the packing offset (18 for DATA_W=8).
- Derived localparam PROD_W = 2*DATA_W.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- a, input, DATA_W, first multiplicand.
- b, input, DATA_W, second multiplicand.
- c, input, DATA_W, shared multiplier.
- i_last, input, 1, marks the final beat of a burst.
- i_valid, input, 1, input beat valid.
- i_ready, output, 1, block accepts a beat this cycle.
- prod_ac, output, OUT_W, a*c result. OUT_W = ACC_W with the macro, PROD_W without.
- prod_bc, output, OUT_W, b*c result.
- o_last, output, 1, last flag travelling with the result.
- o_valid, output, 1, result valid.
- o_ready, input, 1, downstream accepts the result.

Behaviour:
- Reset: o_valid=0, o_last=0, prod_ac=0, prod_bc=0, all internal valid bits=0, accumulator state cleared.
  - i_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight beat; nothing is emitted afterwards.
- Pipeline enable: en = ~o_valid | o_ready; i_ready = en.
  - All three stages, including their valid/last bits, advance only when en=1.
  - The pipeline freezes as a whole; bubbles are not collapsed.
  - A beat is accepted when i_valid & i_ready. A result is consumed when o_valid & o_ready.
  - Data payload registers load only when their incoming valid bit is 1, which saves power.
- Latency: 3 cycles from acceptance to o_valid with o_ready held high. Throughput is 1 beat/cycle.
- Stage 1 (pre-add): pre = (a << SHIFT) + ext(b).
  - ext is sign-extension when SIGNED=1 and zero-extension when SIGNED=0.
  - pre width is SHIFT+DATA_W+1. c is registered alongside.
- Stage 2 (multiply): m = pre * c, full-width signed (SIGNED=1) or unsigned (SIGNED=0).
- Stage 3 (unpack):
  - prod_bc = m[PROD_W-1:0].
  - SIGNED=1: prod_ac = m[SHIFT+PROD_W-1:SHIFT] + m[SHIFT-1], the borrow correction for negative b*c.
  - SIGNED=0: prod_ac = m[SHIFT+PROD_W-1:SHIFT] with no correction.
- Both products are exact for every input combination, including the most negative values.
- While o_valid=1 and o_ready=0, the outputs hold stable and i_ready=0.

Optional Feature:
- Macro: MULT_DUAL_ACC_EN.
- Defined: a stage-4 accumulator after the unpack stage, producing per-burst sums.
  - Per channel, on each beat: acc <= (first ? 0 : acc) + sext/zext(prod) to ACC_W bits.
  - The first flag is set by reset and by every beat with last=1.
  - o_valid pulses only for the beat with last=1; it carries the completed sums and o_last=1.
  - Non-last beats produce no output handshake.
  - Sums wrap modulo 2^ACC_W.
  - Latency from the last beat's acceptance to o_valid is 4 cycles.
  - The same en/backpressure rule applies, with o_valid as the stage-4 valid.
- Undefined: no accumulator. Each accepted beat yields one result after 3 cycles; o_last passes i_last through unchanged; OUT_W=PROD_W.

Decomposition:
- Package mult_dual_pkg holds:
  - the function computing SHIFT from DATA_W;
  - PROD_W;
  - the DSP limit constants (27-bit pre-adder, 18-bit B port);
  - elaboration-time parameter checks, with $error if DATA_W is outside 4..8.
- Sub-module mult_dual_acc implements the two-channel burst accumulator.
  - It is instantiated only under MULT_DUAL_ACC_EN.
  - The packed datapath stays in the top module so it maps to a single DSP.

Test Plan:
- SIGNED=1, DATA_W=8, a=5, b=-3, c=7, o_ready=1 -> 3 cycles later prod_ac=35, prod_bc=-21, o_valid for exactly 1 cycle.
- SIGNED=1, a=b=c=-128 -> prod_ac=16384, prod_bc=16384. Then a=127, b=-128, c=-1 -> prod_ac=-127, prod_bc=128.
- SIGNED=0, a=b=c=255 -> prod_ac=prod_bc=65025. Then a=0, b=1, c=255 -> prod_ac=0, prod_bc=255.
- Stream 6 back-to-back beats with o_ready=0 for cycles 4..7 -> i_ready=0 while o_valid is held, outputs stable, all 6 results delivered in order, none dropped or duplicated.
- Assert rst with 2 beats in flight -> o_valid stays 0 afterwards. A new beat a=2, b=3, c=4 -> prod_ac=8, prod_bc=12 after 3 cycles.
- MULT_DUAL_ACC_EN: burst a=1,2,3, b=-1, c=4, last on beat 3 -> single o_valid with prod_ac=24, prod_bc=-12, o_last=1. An immediate second burst a=1, c=1, last -> prod_ac=1, proving the restart.
